// File: rtl/mem_arbiter_pkg.sv
// mem_arbiter_pkg: shared types and constants for the I/D memory arbiter.
// FSM state codes, chip/write enable levels, default timing parameters and
// a saturating increment used by the optional MEM_ARB_STATS_EN counters.
package mem_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        BUSY_I = 2'b01,
        BUSY_D = 2'b10
    } arb_state_e;

    localparam logic CHIP_ENABLE   = 1'b1;
    localparam logic CHIP_DISABLE  = 1'b0;
    localparam logic WRITE_ENABLE  = 1'b1;
    localparam logic WRITE_DISABLE = 1'b0;

    localparam int unsigned DEF_WAIT_CYC   = 1;
    localparam int unsigned DEF_STARVE_MAX = 4;

    // Both the wait counter and the starvation counter cover 0..15.
    localparam int unsigned WAIT_W   = 4;
    localparam int unsigned STARVE_W = 4;

    function automatic logic [31:0] sat_inc32(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

endpackage

// File: rtl/mem_arb_starve_cnt.sv
// mem_arb_starve_cnt: saturating count of D grants taken while I was waiting.
// clr_i has priority over inc_i; sat_o flags that I must win the next arbitration.
module mem_arb_starve_cnt
    import mem_arbiter_pkg::*;
#(
    parameter int unsigned STARVE_MAX = DEF_STARVE_MAX
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic inc_i,
    input  logic clr_i,
    output logic sat_o
);

    localparam logic [STARVE_W-1:0] CNT_MAX = STARVE_W'(STARVE_MAX);

    logic [STARVE_W-1:0] cnt_q;

    assign sat_o = (cnt_q == CNT_MAX);

    // Clear wins; otherwise count up until the limit is reached and hold there.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else if (clr_i) begin
            cnt_q <= '0;
        end else if (inc_i && !sat_o) begin
            cnt_q <= cnt_q + STARVE_W'(1);
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one single-port synchronous SRAM between the openMIPS
// instruction-fetch (I) and data (D) ports using req/ack handshakes and
// WAIT_CYC wait states per access. D has priority unless I has been passed
// over STARVE_MAX times in a row. Define MEM_ARB_STATS_EN to add saturating
// grant and contention counters on extra output ports.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int unsigned ADDR_W     = 32,
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned WAIT_CYC   = DEF_WAIT_CYC,
    parameter int unsigned STARVE_MAX = DEF_STARVE_MAX
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_req,
    input  logic [ADDR_W-1:0]     i_addr,
    output logic [DATA_W-1:0]     i_rdata,
    output logic                  i_ack,
    input  logic                  d_req,
    input  logic                  d_we,
    input  logic [ADDR_W-1:0]     d_addr,
    input  logic [DATA_W-1:0]     d_wdata,
    input  logic [DATA_W/8-1:0]   d_sel,
    output logic [DATA_W-1:0]     d_rdata,
    output logic                  d_ack,
    output logic                  mem_ce,
    output logic                  mem_we,
    output logic [ADDR_W-1:0]     mem_addr,
    output logic [DATA_W-1:0]     mem_wdata,
    output logic [DATA_W/8-1:0]   mem_sel,
    input  logic [DATA_W-1:0]     mem_rdata,
    output logic                  stallreq
`ifdef MEM_ARB_STATS_EN
    ,
    output logic [31:0]           stat_i_grants,
    output logic [31:0]           stat_d_grants,
    output logic [31:0]           stat_conflicts
`endif
);

    localparam logic [WAIT_W-1:0] WAIT_INIT = WAIT_W'(WAIT_CYC);

    arb_state_e             state_q;
    logic [WAIT_W-1:0]      wait_cnt_q;
    logic                   mem_ce_q;
    logic                   mem_we_q;
    logic [ADDR_W-1:0]      mem_addr_q;
    logic [DATA_W-1:0]      mem_wdata_q;
    logic [DATA_W/8-1:0]    mem_sel_q;
    logic                   i_ack_q;
    logic                   d_ack_q;
    logic [DATA_W-1:0]      i_rdata_q;
    logic [DATA_W-1:0]      d_rdata_q;

    logic completing;
    logic can_grant;
    logic i_elig;
    logic d_elig;
    logic grant_i;
    logic grant_d;
    logic starve_sat;
    logic starve_inc;
    logic starve_clr;
    logic i_pend;
    logic d_pend;

    assign completing = (state_q != IDLE) && (wait_cnt_q == '0);
    assign can_grant  = (state_q == IDLE) || completing;
    // The requester finishing at this edge must not be re-granted on its stale req.
    assign i_elig     = i_req && !(completing && (state_q == BUSY_I));
    assign d_elig     = d_req && !(completing && (state_q == BUSY_D));

    assign i_pend   = i_req & ~i_ack_q;
    assign d_pend   = d_req & ~d_ack_q;
    assign stallreq = i_pend | d_pend;

    // Arbitration: D first, unless I has been starved to the limit.
    always_comb begin
        grant_i = 1'b0;
        grant_d = 1'b0;
        if (can_grant) begin
            if (starve_sat && i_elig) begin
                grant_i = 1'b1;
            end else if (d_elig) begin
                grant_d = 1'b1;
            end else if (i_elig) begin
                grant_i = 1'b1;
            end
        end
    end

    assign starve_inc = grant_d & i_req;
    assign starve_clr = grant_i | ~i_req;

    mem_arb_starve_cnt #(
        .STARVE_MAX (STARVE_MAX)
    ) u_starve_cnt (
        .clk_i  (clk),
        .rst_ni (rst),
        .inc_i  (starve_inc),
        .clr_i  (starve_clr),
        .sat_o  (starve_sat)
    );

    // Access FSM: latch grants into the SRAM registers, count wait states, pulse acks.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            wait_cnt_q  <= '0;
            mem_ce_q    <= CHIP_DISABLE;
            mem_we_q    <= WRITE_DISABLE;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_sel_q   <= '0;
            i_ack_q     <= 1'b0;
            d_ack_q     <= 1'b0;
            i_rdata_q   <= '0;
            d_rdata_q   <= '0;
        end else begin
            i_ack_q <= 1'b0;
            d_ack_q <= 1'b0;

            if (completing) begin
                if (state_q == BUSY_I) begin
                    i_ack_q   <= 1'b1;
                    i_rdata_q <= mem_rdata;
                end else begin
                    d_ack_q   <= 1'b1;
                    d_rdata_q <= mem_rdata;
                end
            end

            if (grant_i) begin
                state_q     <= BUSY_I;
                wait_cnt_q  <= WAIT_INIT;
                mem_ce_q    <= CHIP_ENABLE;
                mem_we_q    <= WRITE_DISABLE;
                mem_addr_q  <= i_addr;
                mem_wdata_q <= '0;
                mem_sel_q   <= '1;
            end else if (grant_d) begin
                state_q     <= BUSY_D;
                wait_cnt_q  <= WAIT_INIT;
                mem_ce_q    <= CHIP_ENABLE;
                mem_we_q    <= d_we ? WRITE_ENABLE : WRITE_DISABLE;
                mem_addr_q  <= d_addr;
                mem_wdata_q <= d_wdata;
                mem_sel_q   <= d_sel;
            end else if (completing) begin
                state_q     <= IDLE;
                mem_ce_q    <= CHIP_DISABLE;
                mem_we_q    <= WRITE_DISABLE;
                mem_addr_q  <= '0;
                mem_wdata_q <= '0;
                mem_sel_q   <= '0;
            end else if (state_q != IDLE) begin
                wait_cnt_q  <= wait_cnt_q - WAIT_W'(1);
            end
        end
    end

    assign mem_ce    = mem_ce_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign mem_sel   = mem_sel_q;
    assign i_ack     = i_ack_q;
    assign d_ack     = d_ack_q;
    assign i_rdata   = i_rdata_q;
    assign d_rdata   = d_rdata_q;

`ifdef MEM_ARB_STATS_EN
    logic [31:0] stat_i_q;
    logic [31:0] stat_d_q;
    logic [31:0] stat_c_q;

    // Saturating counters: grants per port and cycles where I waited behind a pending D.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stat_i_q <= '0;
            stat_d_q <= '0;
            stat_c_q <= '0;
        end else begin
            if (grant_i) begin
                stat_i_q <= sat_inc32(stat_i_q);
            end
            if (grant_d) begin
                stat_d_q <= sat_inc32(stat_d_q);
            end
            if (i_pend && d_pend && !grant_i) begin
                stat_c_q <= sat_inc32(stat_c_q);
            end
        end
    end

    assign stat_i_grants  = stat_i_q;
    assign stat_d_grants  = stat_d_q;
    assign stat_conflicts = stat_c_q;
`endif

endmodule
